// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-ported data memory between the CPU load/store
//            path and a secondary DMA/debug requester. The CPU normally wins;
//            a starvation counter forces a DMA grant after STARVE_LIMIT
//            consecutive denied cycles, and multi-beat DMA bursts lock the
//            memory to the DMA (with CPU gap-fill when the DMA idles).
// Ports    : clk_i, reset_i          - clock, async active-high reset
//            cpu_*                   - CPU request/grant/stall/read-return
//            dma_*                   - DMA beat request/grant/read-return
//            mem_*                   - memory port (read data 1 cycle later)
//            stat_*                  - optional statistics counters
// Options  : DMEM_ARB_STATS_EN - adds stat_cpu_stall_o / stat_dma_beats_o
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int LEN_W        = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic [3:0]        cpu_mask_i,
    output logic              cpu_gnt_o,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    input  logic [LEN_W-1:0]  dma_len_i,
    output logic              dma_gnt_o,
    output logic              dma_rvalid_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_mask_o,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]       stat_cpu_stall_o,
    output logic [31:0]       stat_dma_beats_o,
`endif
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [0:0]       c_arb_cpu      = 1'b0;
    localparam logic [0:0]       c_arb_dma      = 1'b1;
    localparam logic [7:0]       c_starve_limit = 8'(STARVE_LIMIT);
    localparam logic [LEN_W-1:0] c_len_one      = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_len_zero     = '0;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [7:0]       r_starve_cnt;
    logic [7:0]       w_starve_nxt;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] w_remaining_nxt;
    logic             r_rvalid;
    logic             r_owner_dma;
    logic             w_cpu_gnt;
    logic             w_dma_gnt;
    logic             w_rd_accept;

    // ------------------------------------------------------------------
    // Grant decision. Grants are held low while reset is asserted so the
    // memory port is quiet even though requesters may still be asserting.
    // ------------------------------------------------------------------
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (!reset_i) begin
            if (r_state == c_arb_dma) begin
                // Locked burst: DMA owns the port, CPU only fills idle gaps.
                w_dma_gnt = dma_req_i;
                w_cpu_gnt = cpu_req_i & ~dma_req_i;
            end else begin
                if (dma_req_i && (r_starve_cnt == c_starve_limit)) begin
                    w_dma_gnt = 1'b1;
                end else if (cpu_req_i) begin
                    w_cpu_gnt = 1'b1;
                end else if (dma_req_i) begin
                    w_dma_gnt = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: burst length is captured only on the first beat; the
    // beat that consumes remaining==1 ends the burst.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        if (w_dma_gnt) begin
            if (r_state == c_arb_cpu) begin
                w_remaining_nxt = dma_len_i;
                if (dma_len_i != c_len_zero) begin
                    w_state_nxt = c_arb_dma;
                end
            end else begin
                w_remaining_nxt = r_remaining - c_len_one;
                if (r_remaining == c_len_one) begin
                    w_state_nxt = c_arb_cpu;
                end
            end
        end
    end

    // Saturating count of consecutive denied DMA-request cycles.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!dma_req_i || w_dma_gnt) begin
            w_starve_nxt = 8'd0;
        end else if (r_starve_cnt < c_starve_limit) begin
            w_starve_nxt = r_starve_cnt + 8'd1;
        end
    end

    assign w_rd_accept = (w_cpu_gnt & ~cpu_we_i) | (w_dma_gnt & ~dma_we_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= c_arb_cpu;
            r_starve_cnt <= 8'd0;
            r_remaining  <= '0;
            r_rvalid     <= 1'b0;
            r_owner_dma  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_remaining  <= w_remaining_nxt;
            r_rvalid     <= w_rd_accept;
            r_owner_dma  <= w_dma_gnt;
        end
    end

    // ------------------------------------------------------------------
    // Memory port mux. DMA beats are always full-word, so mask is forced.
    // ------------------------------------------------------------------
    always_comb begin
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_mask_o  = 4'b0000;
        if (w_cpu_gnt) begin
            mem_re_o    = ~cpu_we_i;
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
            mem_mask_o  = cpu_mask_i;
        end else if (w_dma_gnt) begin
            mem_re_o    = ~dma_we_i;
            mem_we_o    = dma_we_i;
            mem_addr_o  = dma_addr_i;
            mem_wdata_o = dma_wdata_i;
            mem_mask_o  = 4'b1111;
        end
    end

    assign cpu_gnt_o    = w_cpu_gnt;
    assign dma_gnt_o    = w_dma_gnt;
    assign cpu_stall_o  = cpu_req_i & ~w_cpu_gnt;
    assign cpu_rvalid_o = r_rvalid & ~r_owner_dma;
    assign dma_rvalid_o = r_rvalid & r_owner_dma;
    assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
    assign dma_rdata_o  = dma_rvalid_o ? mem_rdata_i : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] r_stat_cpu_stall;
    logic [31:0] r_stat_dma_beats;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_stat_cpu_stall <= 32'd0;
            r_stat_dma_beats <= 32'd0;
        end else begin
            if (cpu_stall_o) begin
                r_stat_cpu_stall <= r_stat_cpu_stall + 32'd1;
            end
            if (w_dma_gnt) begin
                r_stat_dma_beats <= r_stat_dma_beats + 32'd1;
            end
        end
    end

    assign stat_cpu_stall_o = r_stat_cpu_stall;
    assign stat_dma_beats_o = r_stat_dma_beats;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter. Inputs change on
//            the falling edge; outputs are sampled 1 ns later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [3:0]  cpu_mask_i;
    logic        cpu_gnt_o;
    logic        cpu_stall_o;
    logic        cpu_rvalid_o;
    logic [31:0] cpu_rdata_o;
    logic        dma_req_i;
    logic        dma_we_i;
    logic [31:0] dma_addr_i;
    logic [31:0] dma_wdata_i;
    logic [3:0]  dma_len_i;
    logic        dma_gnt_o;
    logic        dma_rvalid_o;
    logic [31:0] dma_rdata_o;
    logic        mem_re_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_mask_o;
    logic [31:0] mem_rdata_i;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu_stall_o;
    logic [31:0] stat_dma_beats_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8), .LEN_W(4)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_mask_i(cpu_mask_i),
        .cpu_gnt_o(cpu_gnt_o), .cpu_stall_o(cpu_stall_o),
        .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
        .dma_wdata_i(dma_wdata_i), .dma_len_i(dma_len_i),
        .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o),
        .dma_rdata_o(dma_rdata_o),
        .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_mask_o(mem_mask_o),
`ifdef DMEM_ARB_STATS_EN
        .stat_cpu_stall_o(stat_cpu_stall_o),
        .stat_dma_beats_o(stat_dma_beats_o),
`endif
        .mem_rdata_i(mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    initial begin
        reset_i     = 1'b1;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h0;
        cpu_wdata_i = 32'h0;
        cpu_mask_i  = 4'b0000;
        dma_req_i   = 1'b0;
        dma_we_i    = 1'b0;
        dma_addr_i  = 32'h0;
        dma_wdata_i = 32'h0;
        dma_len_i   = 4'd0;
        mem_rdata_i = 32'h0;

        // ---- reset state (requests present but must be ignored) ----
        step();
        cpu_req_i = 1'b1;
        dma_req_i = 1'b1;
        #1;
        chk("rst_cpu_gnt",    32'(cpu_gnt_o),    32'd0);
        chk("rst_dma_gnt",    32'(dma_gnt_o),    32'd0);
        chk("rst_mem_re",     32'(mem_re_o),     32'd0);
        chk("rst_mem_we",     32'(mem_we_o),     32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid_o), 32'd0);
        chk("rst_dma_rvalid", 32'(dma_rvalid_o), 32'd0);
        step();
        reset_i   = 1'b0;
        cpu_req_i = 1'b0;
        dma_req_i = 1'b0;

        // ---- CPU-only read ----
        step();
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h100;
        cpu_mask_i = 4'b0101;
        #1;
        chk("t1_cpu_gnt",   32'(cpu_gnt_o),   32'd1);
        chk("t1_cpu_stall", 32'(cpu_stall_o), 32'd0);
        chk("t1_mem_re",    32'(mem_re_o),    32'd1);
        chk("t1_mem_addr",  mem_addr_o,       32'h100);
        chk("t1_mem_mask",  32'(mem_mask_o),  32'h5);
        step();
        cpu_req_i   = 1'b0;
        mem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("t1_cpu_rvalid", 32'(cpu_rvalid_o), 32'd1);
        chk("t1_cpu_rdata",  cpu_rdata_o,        32'hDEADBEEF);
        chk("t1_dma_rvalid", 32'(dma_rvalid_o), 32'd0);
        chk("t1_dma_rdata",  dma_rdata_o,        32'h0);
        chk("t1_idle_re",    32'(mem_re_o),     32'd0);
        chk("t1_idle_addr",  mem_addr_o,         32'h0);

        // ---- simultaneous single requests ----
        step();
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b1;
        cpu_wdata_i = 32'h11;
        cpu_addr_i  = 32'h104;
        dma_req_i   = 1'b1;
        dma_we_i    = 1'b0;
        dma_addr_i  = 32'h200;
        dma_len_i   = 4'd0;
        #1;
        chk("t2_cpu_gnt",   32'(cpu_gnt_o),   32'd1);
        chk("t2_dma_gnt",   32'(dma_gnt_o),   32'd0);
        chk("t2_cpu_stall", 32'(cpu_stall_o), 32'd0);
        chk("t2_mem_we",    32'(mem_we_o),    32'd1);
        chk("t2_mem_wdata", mem_wdata_o,      32'h11);
        step();
        cpu_req_i = 1'b0;
        #1;
        chk("t2_dma_gnt2",   32'(dma_gnt_o),    32'd1);
        chk("t2_mem_re",     32'(mem_re_o),     32'd1);
        chk("t2_mem_addr",   mem_addr_o,        32'h200);
        chk("t2_mem_mask",   32'(mem_mask_o),   32'hF);
        chk("t2_no_wr_rval", 32'(cpu_rvalid_o), 32'd0);
        step();
        dma_req_i   = 1'b0;
        mem_rdata_i = 32'hCAFE;
        #1;
        chk("t2_dma_rvalid", 32'(dma_rvalid_o), 32'd1);
        chk("t2_dma_rdata",  dma_rdata_o,        32'hCAFE);
        chk("t2_cpu_rvalid", 32'(cpu_rvalid_o), 32'd0);
        chk("t2_cpu_rdata",  cpu_rdata_o,        32'h0);

        // ---- starvation: DMA forced on cycle 8, then counter restarts ----
        step();
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h108;
        dma_req_i  = 1'b1;
        dma_we_i   = 1'b1;
        dma_addr_i = 32'h240;
        dma_len_i  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            #1;
            chk($sformatf("t3_denied_%0d", i), 32'(dma_gnt_o), 32'd0);
        end
        step();
        #1;
        chk("t3_forced_dma", 32'(dma_gnt_o),   32'd1);
        chk("t3_cpu_gnt",    32'(cpu_gnt_o),   32'd0);
        chk("t3_cpu_stall",  32'(cpu_stall_o), 32'd1);
        chk("t3_mem_we",     32'(mem_we_o),    32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            #1;
            chk($sformatf("t3_redeny_%0d", i), 32'(dma_gnt_o), 32'd0);
            if (i == 0) begin
                chk("t3_wr_no_rval", 32'(cpu_rvalid_o | dma_rvalid_o), 32'd0);
            end
        end
        step();
        #1;
        chk("t3_forced_again", 32'(dma_gnt_o), 32'd1);
        step();
        cpu_req_i = 1'b0;
        dma_req_i = 1'b0;

        // ---- locked 4-beat write burst while CPU keeps requesting ----
        step();
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b0;
        dma_req_i   = 1'b1;
        dma_we_i    = 1'b1;
        dma_len_i   = 4'd3;
        dma_addr_i  = 32'h300;
        dma_wdata_i = 32'h5000;
        repeat (8) step();
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                step();
                dma_len_i   = 4'd0;
                dma_addr_i  = dma_addr_i + 32'd4;
                dma_wdata_i = dma_wdata_i + 32'd1;
            end
            #1;
            chk($sformatf("t4_dma_gnt_%0d", b),   32'(dma_gnt_o),   32'd1);
            chk($sformatf("t4_stall_%0d", b),     32'(cpu_stall_o), 32'd1);
            chk($sformatf("t4_mask_%0d", b),      32'(mem_mask_o),  32'hF);
            chk($sformatf("t4_addr_%0d", b),      mem_addr_o,       32'h300 + 32'(b) * 32'd4);
            chk($sformatf("t4_wdata_%0d", b),     mem_wdata_o,      32'h5000 + 32'(b));
        end
        step();
        #1;
        chk("t4_back_cpu_gnt", 32'(cpu_gnt_o), 32'd1);
        chk("t4_back_dma_gnt", 32'(dma_gnt_o), 32'd0);
        step();
        cpu_req_i = 1'b0;
        dma_req_i = 1'b0;

        // ---- read burst with a 2-cycle DMA gap filled by CPU reads ----
        step();
        dma_req_i   = 1'b1;
        dma_we_i    = 1'b0;
        dma_len_i   = 4'd3;
        dma_addr_i  = 32'h400;
        mem_rdata_i = 32'hA0;
        #1;
        chk("t5_k0_dma_gnt", 32'(dma_gnt_o), 32'd1);
        step();
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h500;
        dma_len_i   = 4'd0;
        mem_rdata_i = 32'hA1;
        #1;
        chk("t5_k1_dma_gnt",   32'(dma_gnt_o),    32'd1);
        chk("t5_k1_stall",     32'(cpu_stall_o),  32'd1);
        chk("t5_k1_dma_rval",  32'(dma_rvalid_o), 32'd1);
        chk("t5_k1_dma_rdata", dma_rdata_o,       32'hA1);
        step();
        dma_req_i   = 1'b0;
        mem_rdata_i = 32'hA2;
        #1;
        chk("t5_k2_cpu_gnt",   32'(cpu_gnt_o),    32'd1);
        chk("t5_k2_dma_rdata", dma_rdata_o,       32'hA2);
        step();
        mem_rdata_i = 32'hA3;
        #1;
        chk("t5_k3_cpu_gnt",   32'(cpu_gnt_o),    32'd1);
        chk("t5_k3_cpu_rval",  32'(cpu_rvalid_o), 32'd1);
        chk("t5_k3_cpu_rdata", cpu_rdata_o,       32'hA3);
        chk("t5_k3_dma_rval",  32'(dma_rvalid_o), 32'd0);
        step();
        dma_req_i   = 1'b1;
        mem_rdata_i = 32'hA4;
        #1;
        chk("t5_k4_dma_gnt",   32'(dma_gnt_o),    32'd1);
        chk("t5_k4_cpu_rval",  32'(cpu_rvalid_o), 32'd1);
        step();
        mem_rdata_i = 32'hA5;
        #1;
        chk("t5_k5_dma_gnt",   32'(dma_gnt_o),    32'd1);
        chk("t5_k5_dma_rdata", dma_rdata_o,       32'hA5);
        chk("t5_k5_cpu_rval",  32'(cpu_rvalid_o), 32'd0);
        step();
        #1;
        chk("t5_k6_cpu_gnt",   32'(cpu_gnt_o),    32'd1);
        chk("t5_k6_dma_gnt",   32'(dma_gnt_o),    32'd0);
        step();
        cpu_req_i = 1'b0;
        dma_req_i = 1'b0;

        // ---- reset mid-burst with a DMA read in flight ----
        step();
        dma_req_i  = 1'b1;
        dma_we_i   = 1'b0;
        dma_len_i  = 4'd3;
        dma_addr_i = 32'h600;
        #1;
        chk("t6_k0_dma_gnt", 32'(dma_gnt_o), 32'd1);
        step();
        cpu_req_i = 1'b1;
        #1;
        chk("t6_k1_dma_gnt", 32'(dma_gnt_o), 32'd1);
        step();
        reset_i     = 1'b1;
        mem_rdata_i = 32'hBAD;
        #1;
        chk("t6_rst_dma_gnt", 32'(dma_gnt_o),    32'd0);
        chk("t6_rst_cpu_gnt", 32'(cpu_gnt_o),    32'd0);
        chk("t6_rst_dma_rv",  32'(dma_rvalid_o), 32'd0);
        chk("t6_rst_cpu_rv",  32'(cpu_rvalid_o), 32'd0);
        chk("t6_rst_mem_re",  32'(mem_re_o),     32'd0);
        chk("t6_rst_rdata",   dma_rdata_o,       32'h0);
        step();
        reset_i = 1'b0;
        #1;
        chk("t6_post_cpu_gnt", 32'(cpu_gnt_o), 32'd1);
        chk("t6_post_dma_gnt", 32'(dma_gnt_o), 32'd0);
        step();
        cpu_req_i = 1'b0;
        dma_req_i = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-ported data memory between the CPU load/store path (EX-stage address, write data, sign mask) and a secondary DMA/debug requester. The CPU has default priority; the DMA gets bounded-latency access through a starvation counter and performs locked bursts. It sits between the cpu data-memory port and the data memory, and drives the CPU stall request while the CPU is denied.

Parameters:
ADDR_W, 32, address width of both requesters and memory
DATA_W, 32, data width
STARVE_LIMIT, 8, consecutive denied DMA-request cycles before DMA is forced a grant (legal range 1..255)
LEN_W, 4, width of DMA burst-length field (max burst = 2^LEN_W beats)

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous reset, active high
cpu_req_i  in  1  CPU access request (load or store)
cpu_we_i  in  1  1=store, 0=load
cpu_addr_i  in  ADDR_W  CPU byte address
cpu_wdata_i  in  DATA_W  CPU store data
cpu_mask_i  in  4  CPU sign/byte mask, passed through
cpu_gnt_o  out  1  CPU access accepted this cycle
cpu_stall_o  out  1  cpu_req_i & ~cpu_gnt_o
cpu_rvalid_o  out  1  CPU read data valid
cpu_rdata_o  out  DATA_W  CPU read data
dma_req_i  in  1  DMA beat request
dma_we_i  in  1  1=write, 0=read
dma_addr_i  in  ADDR_W  DMA address
dma_wdata_i  in  DATA_W  DMA write data
dma_len_i  in  LEN_W  burst beats minus 1, sampled on first beat only
dma_gnt_o  out  1  DMA beat accepted this cycle
dma_rvalid_o  out  1  DMA read data valid
dma_rdata_o  out  DATA_W  DMA read data
mem_re_o  out  1  memory read enable
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_mask_o  out  4  memory sign mask (DMA beats force 4'b1111)
mem_rdata_i  in  DATA_W  memory read data, valid 1 cycle after mem_re_o

Behaviour:
- Handshake: a beat transfers in the cycle req & gnt are both high; gnt is combinational from req and registered state; at most one gnt high per cycle; requester holds req/addr/data stable until granted.
- Memory side driven combinationally from the granted requester; no grant -> re=we=0, addr/wdata/mask=0.
- FSM states: ARB_CPU (reset/default), ARB_DMA (locked burst).
- ARB_CPU: if starve_cnt==STARVE_LIMIT and dma_req -> grant DMA (even if cpu_req); else if cpu_req -> grant CPU; else if dma_req -> grant DMA. On any DMA grant: remaining <= dma_len_i; if dma_len_i!=0 -> ARB_DMA.
- starve_cnt (8-bit): +1 each cycle dma_req & ~dma_gnt, saturating at STARVE_LIMIT; cleared on any DMA grant or when dma_req low.
- ARB_DMA: DMA granted whenever dma_req; each accepted beat remaining-1; beat with remaining==1 accepted -> ARB_CPU. Cycles with dma_req low: CPU granted if cpu_req (gap fill), state held.
- Read return: registered owner+valid flag; cycle after an accepted read, exactly one of cpu_rvalid_o/dma_rvalid_o =1 and its rdata = mem_rdata_i; non-owner rdata = 0. Writes produce no rvalid.
- Back-to-back reads from alternating owners return in grant order, one per cycle.
- Reset (async, any state, mid-burst): state ARB_CPU, starve_cnt=0, remaining=0, rvalid outputs 0, gnts 0 and mem_re/we 0 while reset_i high; in-flight read is discarded.

Optional Feature:
DMEM_ARB_STATS_EN: when defined, adds outputs stat_cpu_stall_o[31:0] (cycles with cpu_stall_o=1) and stat_dma_beats_o[31:0] (accepted DMA beats), both wrapping at 2^32, cleared by reset. When undefined these ports and counters do not exist; all other behaviour identical.

Test Plan:
- CPU-only: cpu read addr 0x100, mem returns 0xDEADBEEF -> cpu_gnt same cycle, cpu_rvalid next cycle with 0xDEADBEEF, dma_rvalid 0.
- Simultaneous single requests in ARB_CPU, starve_cnt 0 -> CPU granted, cpu_stall 0, DMA granted following cycle after cpu_req drops.
- CPU requests continuously, DMA requests from cycle 0, STARVE_LIMIT=8 -> DMA granted on cycle 8, cpu_stall_o=1 exactly that cycle, starve_cnt back to 0.
- DMA burst dma_len_i=3 (4 writes) while CPU requests -> 4 consecutive dma_gnt, cpu_stall 4 cycles, FSM back to ARB_CPU, mem_mask 4'b1111 on each beat.
- Burst with dma_req dropped for 2 cycles mid-burst -> CPU gap-filled those cycles, burst completes remaining beats, state ARB_CPU after last.
- reset_i asserted during burst with read in flight -> all gnt/rvalid 0 immediately; after release CPU request granted at once.
